elastic_fifo_buffer: RTL and testbench
======================================

# elastic_fifo_buffer

Circular-buffer elastic FIFO for one handshake channel. It decouples a producer from a downstream fork or any other consumer, absorbing up to NUM_SLOTS tokens of back-pressure. Valid and data are registered, so no combinational path runs from ins to outs. Ready is derived from state only, so no combinational path runs from outs_ready to ins_ready. The block is typically placed directly upstream of a fork, so that a stalled fork branch does not stall the producer.

## Interface
- NUM_SLOTS, default 4: storage depth; legal range ≥ 1.
- DATA_TYPE, default 32: token width in bits; legal range ≥ 1.

- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-low (0 = reset, sampled on the clk edge).
- ins  input  DATA_TYPE  input token data.
- ins_valid  input  1  input token present.
- ins_ready  output  1  buffer can accept a token this cycle.
- outs  output  DATA_TYPE  head token data.
- outs_valid  output  1  head token present.
- outs_ready  input  1  consumer accepts the head token this cycle.

## Operation
- State:
  - storage array mem[NUM_SLOTS] of DATA_TYPE;
  - head pointer (read) and tail pointer (write), each PTR_W = max(1, clog2(NUM_SLOTS)) bits;
  - occupancy count, CNT_W = clog2(NUM_SLOTS+1) bits.
- Derived signals:
  - empty = (count == 0); full = (count == NUM_SLOTS).
  - ins_ready = !full; outs_valid = !empty; outs = mem[head].
- Events:
  - push = ins_valid & ins_ready.
  - pop = outs_valid & outs_ready.
- On push: mem[tail] <= ins; tail advances by one.
- On pop: head advances by one.
- Pointer wrap: a pointer at NUM_SLOTS-1 advances to 0. Wrap is explicit compare-and-clear, not modulo-2^n, so non-power-of-two depths work.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - Legal whenever 0 < count < NUM_SLOTS. Full throughput is 1 token per cycle.
  - When full, ins_ready = 0, so push cannot occur in the same cycle as a pop. The freed slot is offered on the next cycle.
  - When empty, pop cannot occur. A push into an empty buffer becomes visible on outs one cycle later; there is no bypass.
- Data is never lost or duplicated. Order is strictly FIFO.
- mem contents are not reset. outs is don't-care while outs_valid = 0, and the bench must not check it then.

## Timing
- Reset (rst = 0 at a clk edge):
  - head = tail = 0, count = 0;
  - next cycle outputs: outs_valid = 0, ins_ready = 1.
- Reset mid-operation: all stored tokens are discarded; there is no partial drain. During rst = 0 cycles, push/pop events are ignored.
- Latency: a token accepted at edge N appears on outs with outs_valid = 1 after edge N (cycle N+1).
- Throughput: 1 token/cycle in steady state with outs_ready held high.
- Full recovery: from full, after a pop at edge N, ins_ready = 1 in cycle N+1.
- outs_valid and ins_ready are functions of registered state only, so both are glitch-free and independent of same-cycle inputs.
- Handshake rules:
  - Once outs_valid = 1, outs_valid and outs stay stable until pop.
  - ins_ready may be asserted without ins_valid.

## Structure
- Shared handshake package: a clog2-with-minimum-1 helper function used for PTR_W and CNT_W. No new typedefs.
- One sub-module, elastic_fifo_ctrl, holds head, tail and count, plus the wrap and full/empty logic. It exposes push/pop inputs and head, tail, full and empty outputs.
- The top level holds mem and the output data mux.

## Test plan
- Reset then idle: hold rst = 0 for 2 cycles, then release → outs_valid = 0 and ins_ready = 1 in every cycle, with ins_valid = 0.
- Streaming (NUM_SLOTS = 4, outs_ready = 1): push 0x11, 0x22, 0x33 on consecutive cycles → outs shows 0x11, 0x22, 0x33 on the next three cycles, one per cycle, with count never exceeding 1.
- Fill and stall (NUM_SLOTS = 4, outs_ready = 0): offer 0xA0..0xA5 every cycle → ins_ready drops after 4 accepts, and only 0xA0..0xA3 are stored. Then raise outs_ready → outs yields 0xA0, 0xA1, 0xA2, 0xA3 in order. ins_ready returns to 1 the cycle after the first pop, and 0xA4 is accepted next.
- Wrap with non-power-of-two depth (NUM_SLOTS = 3): run 10 tokens 1..10 with outs_ready toggling 1,0,1,0,... → outputs are exactly 1..10 in order, with no drop or duplicate and pointers wrapping 2→0.
- Reset mid-operation (NUM_SLOTS = 4): fill with 3 tokens, then assert rst = 0 for one cycle → outs_valid = 0 and ins_ready = 1 in the next cycle. A subsequent push of 0x5A is the first token output.
- Simultaneous push/pop at count = 2: ins_valid = 1 and outs_ready = 1 for 5 cycles → count stays 2 and order is preserved.

Source files
------------

// File: rtl/elastic_fifo_buffer_pkg.sv
// Shared handshake helpers for the elastic FIFO: pointer/count width sizing.
package elastic_fifo_buffer_pkg;

    // clog2 that never returns 0, so a single-slot buffer still gets 1-bit fields.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/elastic_fifo_ctrl.sv
// Head/tail/count bookkeeping for the circular buffer, with explicit pointer wrap
// so any depth (not only powers of two) works.
module elastic_fifo_ctrl
    import elastic_fifo_buffer_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    localparam int PTR_W = clog2_min1(NUM_SLOTS),
    localparam int CNT_W = clog2_min1(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] head_o,
    output logic [PTR_W-1:0] tail_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_SLOTS);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_i) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
        end
        if (push_i) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
        end
        // A simultaneous push and pop leaves occupancy unchanged.
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign full_o  = (count_q == MAX_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/elastic_fifo_buffer.sv
// Elastic FIFO for one valid/ready channel. Outputs depend on registered state only,
// so neither ins->outs nor outs_ready->ins_ready has a combinational path.
module elastic_fifo_buffer
    import elastic_fifo_buffer_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    localparam int PTR_W = clog2_min1(NUM_SLOTS);

    logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
    logic [PTR_W-1:0]     head, tail;
    logic                 full, empty;
    logic                 push, pop;

    assign ins_ready  = !full;
    assign outs_valid = !empty;

    // Events are masked while reset is held so nothing lands in storage.
    assign push = ins_valid & ins_ready & rst;
    assign pop  = outs_valid & outs_ready & rst;

    elastic_fifo_ctrl #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .head_o  (head),
        .tail_o  (tail),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail] <= ins;
        end
    end

    assign outs = mem_q[head];

endmodule

// File: tb/tb_elastic_fifo_buffer.sv
// Scoreboard bench: a depth-4 and a depth-3 instance, tokens queued on accept and
// checked in order on pop; flags and occupancy checked against the model each cycle.
module tb_elastic_fifo_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [2];
    logic [31:0] ins        [2];
    logic        ins_valid  [2];
    logic        ins_ready  [2];
    logic [31:0] outs       [2];
    logic        outs_valid [2];
    logic        outs_ready [2];
    int          cnt_obs    [2];

    elastic_fifo_buffer #(.NUM_SLOTS(4), .DATA_TYPE(32)) dut4 (
        .clk(clk), .rst(rst[0]), .ins(ins[0]), .ins_valid(ins_valid[0]),
        .ins_ready(ins_ready[0]), .outs(outs[0]), .outs_valid(outs_valid[0]),
        .outs_ready(outs_ready[0])
    );

    elastic_fifo_buffer #(.NUM_SLOTS(3), .DATA_TYPE(32)) dut3 (
        .clk(clk), .rst(rst[1]), .ins(ins[1]), .ins_valid(ins_valid[1]),
        .ins_ready(ins_ready[1]), .outs(outs[1]), .outs_valid(outs_valid[1]),
        .outs_ready(outs_ready[1])
    );

    assign cnt_obs[0] = int'(dut4.u_ctrl.count_q);
    assign cnt_obs[1] = int'(dut3.u_ctrl.count_q);

    int          total = 0;
    int          bad   = 0;
    int          slots [2] = '{4, 3};
    logic [31:0] sb    [2][$];
    int          pops  [2] = '{0, 0};
    logic [31:0] last_pop [2];
    bit          chk_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor on the falling edge: inputs and registered outputs are both settled.
    always @(negedge clk) begin
        logic [31:0] exp_d;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("vld%0d", i), outs_valid[i], sb[i].size() != 0);
                chk($sformatf("rdy%0d", i), ins_ready[i], sb[i].size() != slots[i]);
                chk($sformatf("cnt%0d", i), cnt_obs[i], sb[i].size());
                if (rst[i]) begin
                    if (outs_valid[i] && outs_ready[i] && sb[i].size() != 0) begin
                        exp_d = sb[i].pop_front();
                        chk($sformatf("data%0d", i), outs[i], exp_d);
                        last_pop[i] = outs[i];
                        pops[i]++;
                    end
                    if (ins_valid[i] && ins_ready[i]) sb[i].push_back(ins[i]);
                end else begin
                    sb[i].delete();
                end
            end
        end
        if (!rst[0]) chk_en = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, p, nxt;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; ins[i] = '0; ins_valid[i] = 1'b0; outs_ready[i] = 1'b0;
        end
        step(); step();
        rst[0] = 1'b1; rst[1] = 1'b1;
        repeat (3) step();

        // Streaming through an otherwise empty buffer
        outs_ready[0] = 1'b1;
        p = pops[0];
        for (int k = 0; k < 3; k++) begin
            ins_valid[0] = 1'b1;
            ins[0] = 32'h11 * (k + 1);
            step();
            chk("stream_cnt_le1", cnt_obs[0] <= 1, 1);
        end
        ins_valid[0] = 1'b0;
        repeat (3) step();
        chk("stream_pops", pops[0] - p, 3);

        // Fill and stall, then drain
        outs_ready[0] = 1'b0;
        idx = 0;
        p = pops[0];
        for (int c = 0; c < 6; c++) begin
            ins_valid[0] = 1'b1;
            ins[0] = 32'hA0 + idx;
            if (ins_ready[0]) idx++;
            step();
        end
        chk("fill_acc", idx, 4);
        chk("fill_rdy", ins_ready[0], 0);
        outs_ready[0] = 1'b1;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            ins_valid[0] = 1'b1;
            ins[0] = 32'hA0 + idx;
            if (ins_ready[0]) idx++;
            step();
        end
        ins_valid[0] = 1'b0;
        for (int c = 0; c < 20 && sb[0].size() != 0; c++) step();
        chk("fill_pops", pops[0] - p, 6);

        // Depth 3: wrap with toggling back-pressure
        nxt = 1;
        p = pops[1];
        for (int c = 0; c < 80 && (pops[1] - p) < 10; c++) begin
            outs_ready[1] = (c % 2) == 0;
            ins_valid[1]  = nxt <= 10;
            ins[1]        = nxt;
            if (ins_valid[1] && ins_ready[1]) nxt++;
            step();
        end
        ins_valid[1] = 1'b0;
        chk("wrap_pops", pops[1] - p, 10);
        chk("wrap_last", last_pop[1], 10);

        // Reset while holding three tokens
        outs_ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ins_valid[0] = 1'b1;
            ins[0] = 32'h31 + k;
            step();
        end
        ins_valid[0] = 1'b0;
        chk("pre_rst_cnt", cnt_obs[0], 3);
        rst[0] = 1'b0;
        step();
        rst[0] = 1'b1;
        chk("rst_vld", outs_valid[0], 0);
        chk("rst_rdy", ins_ready[0], 1);
        chk("rst_cnt", cnt_obs[0], 0);
        p = pops[0];
        outs_ready[0] = 1'b1;
        ins_valid[0] = 1'b1;
        ins[0] = 32'h5A;
        step();
        ins_valid[0] = 1'b0;
        repeat (2) step();
        chk("rst_first_n", pops[0] - p, 1);
        chk("rst_first", last_pop[0], 32'h5A);

        // Simultaneous push/pop at occupancy 2
        outs_ready[0] = 1'b0;
        p = pops[0];
        for (int k = 0; k < 2; k++) begin
            ins_valid[0] = 1'b1;
            ins[0] = 32'h61 + k;
            step();
        end
        outs_ready[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ins_valid[0] = 1'b1;
            ins[0] = 32'h63 + k;
            step();
            chk("sim_cnt", cnt_obs[0], 2);
        end
        ins_valid[0] = 1'b0;
        for (int c = 0; c < 20 && sb[0].size() != 0; c++) step();
        chk("sim_pops", pops[0] - p, 7);
        chk("sim_last", last_pop[0], 32'h67);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
